// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling FSM, small receive FIFO.
// Optional `define UART_RX_IRQ_EN adds a registered irq output.
module uart_rx #(
  parameter logic [2:0] DEVICE_ADDRESS = 3'b100,
  parameter int         CLKS_PER_BIT   = 87,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  device_select,
  input  logic [15:0] mmio_addr,
  input  logic [7:0]  mmio_data_in,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic        rx,
  output logic [7:0]  mmio_data_out
`ifdef UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_s1, rx_s2, rx_prev;
  logic [1:0]    state;
  logic [15:0]   cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [1:0]    cr;
  logic          ovr, ferr;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  logic sel, rd_cr, rd_sr, rd_di, wr_cr;
  logic tick, empty, full;
  logic push_req, ferr_set, push, pop, ovr_set;
  logic unused_wr_bits;

  assign unused_wr_bits = ^mmio_data_in[7:2];

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign sel   = (device_select == DEVICE_ADDRESS);
  assign rd_cr = sel && mmio_rd && (mmio_addr == 16'h0000);
  assign rd_sr = sel && mmio_rd && (mmio_addr == 16'h0001);
  assign rd_di = sel && mmio_rd && (mmio_addr == 16'h0004);
  assign wr_cr = sel && mmio_wr && (mmio_addr == 16'h0000);

  assign tick     = (cnt == 16'd0);
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push_req = cr[0] && (state == STOP) && tick && rx_s2;
  assign ferr_set = cr[0] && (state == STOP) && tick && !rx_s2;
  assign pop      = rd_di && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);
  assign ovr_set  = push_req && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!cr[0]) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (rx_prev && !rx_s2) begin
          state <= START;
          cnt   <= HALF_CNT;
        end
        START: if (tick) begin
          if (!rx_s2) begin
            state   <= DATA;
            bit_cnt <= '0;
            cnt     <= FULL_CNT;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
        DATA: if (tick) begin
          shreg[bit_cnt] <= rx_s2;
          bit_cnt        <= bit_cnt + 3'd1;
          cnt            <= FULL_CNT;
          if (bit_cnt == 3'd7) state <= STOP;
        end else begin
          cnt <= cnt - 16'd1;
        end
        default: if (tick) state <= IDLE;
                 else      cnt   <= cnt - 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Sticky flags: a set in the same cycle as an SR read wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      cr   <= 2'b00;
    end else begin
      ovr  <= (ovr  && !rd_sr) || ovr_set;
      ferr <= (ferr && !rd_sr) || ferr_set;
      if (wr_cr) cr <= mmio_data_in[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_data_out <= 8'h00;
    end else if (rd_cr) begin
      mmio_data_out <= {6'b0, cr};
    end else if (rd_sr) begin
      mmio_data_out <= {4'b0, ferr, ovr, full, !empty};
    end else if (rd_di) begin
      mmio_data_out <= empty ? 8'h00 : mem[rptr];
    end
  end

`ifdef UART_RX_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= cr[1] && (!empty || ovr || ferr);
  end
`endif

endmodule
